// File: rtl/servo_pkg.sv
// Shared constants for the servo PWM sequencer: Avalon-MM register addresses,
// CTRL/STATUS bit positions, default timing and a pulse-width clamp helper.
package servo_pkg;

  // Register addresses
  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrTarget = 2'd1;
  localparam logic [1:0] AddrStep   = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  // CTRL bits
  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlIrqEnBit  = 1;

  // STATUS bits (CUR occupies 15:0)
  localparam int unsigned StatusBusyBit = 16;
  localparam int unsigned StatusDoneBit = 17;

  // Pulse-width fields are 16 bits; stepping arithmetic uses one extra bit
  localparam int unsigned UsWidth  = 16;
  localparam int unsigned CurWidth = UsWidth + 1;

  // Default timing
  localparam int unsigned DefClkPerUs = 50;
  localparam int unsigned DefPeriodUs = 20000;
  localparam int unsigned DefMinUs    = 1000;
  localparam int unsigned DefMaxUs    = 2000;
  localparam int unsigned DefResetUs  = 1500;

  function automatic logic [UsWidth-1:0] clamp_us(input logic [UsWidth-1:0] value,
                                                  input logic [UsWidth-1:0] lo,
                                                  input logic [UsWidth-1:0] hi);
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end
    return value;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Microsecond tick prescaler.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-high reset
//   enable  - count while high; prescaler held at 0 while low
//   us_tick - one-cycle pulse every CLK_PER_US enabled cycles
module servo_tick_gen #(
  parameter int unsigned CLK_PER_US = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic us_tick
);

  localparam int unsigned PreW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CLK_PER_US - 1);

  logic [PreW-1:0] pre_q, pre_d;

  always_comb begin
    us_tick = enable && (pre_q == PreLast);
    pre_d   = pre_q + 1'b1;
    if (!enable || us_tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/servo_pwm_sequencer.sv
// Servo PWM generator with frame-synchronous ramping of the pulse width.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata  - Avalon-MM slave write side
//   readdata            - Avalon-MM read data, combinational from address
//   pwm_out             - registered servo pulse
//   irq                 - level interrupt, DONE & IRQ_EN
module servo_pwm_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned CLK_PER_US = DefClkPerUs,
  parameter int unsigned PERIOD_US  = DefPeriodUs,
  parameter int unsigned MIN_US     = DefMinUs,
  parameter int unsigned MAX_US     = DefMaxUs,
  parameter int unsigned RESET_US   = DefResetUs
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        pwm_out,
  output logic        irq
);

  localparam int unsigned FrameW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam logic [FrameW-1:0]  FrameLast = FrameW'(PERIOD_US - 1);
  localparam logic [UsWidth-1:0] MinUs     = UsWidth'(MIN_US);
  localparam logic [UsWidth-1:0] MaxUs     = UsWidth'(MAX_US);
  localparam logic [UsWidth-1:0] ResetUs   = UsWidth'(RESET_US);

  logic                enable_q, enable_d;
  logic                irq_en_q, irq_en_d;
  logic [UsWidth-1:0]  target_q, target_d;
  logic [UsWidth-1:0]  step_q, step_d;
  logic [UsWidth-1:0]  cur_q, cur_d;
  logic                done_q, done_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic                pwm_q, pwm_d;

  logic                us_tick;
  logic                wr;
  logic                boundary;
  logic                busy;
  logic [CurWidth-1:0] cur_w, tgt_w, step_w, sum_w, diff_w, dec_w;

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:18], writedata[16]};

  servo_tick_gen #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable_q),
    .us_tick(us_tick)
  );

  assign wr       = chipselect && !write_n;
  assign boundary = us_tick && (frame_q == FrameLast);
  assign busy     = (cur_q != target_q);
  assign irq      = done_q && irq_en_q;
  assign pwm_out  = pwm_q;

  always_comb begin
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    target_d = target_q;
    step_d   = step_q;
    cur_d    = cur_q;
    done_d   = done_q;
    frame_d  = frame_q;
    cur_w    = {1'b0, cur_q};
    tgt_w    = {1'b0, target_q};
    step_w   = {1'b0, step_q};
    sum_w    = cur_w + step_w;
    diff_w   = cur_w - tgt_w;
    dec_w    = cur_w - step_w;

    if (wr) begin
      unique case (address)
        AddrCtrl: begin
          enable_d = writedata[CtrlEnableBit];
          irq_en_d = writedata[CtrlIrqEnBit];
        end
        AddrTarget: target_d = clamp_us(writedata[UsWidth-1:0], MinUs, MaxUs);
        AddrStep:   step_d   = writedata[UsWidth-1:0];
        AddrStatus: begin
          if (writedata[StatusDoneBit]) begin
            done_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Frame counter restarts at 0 whenever ENABLE is (or becomes) low
    if (!enable_d) begin
      frame_d = '0;
    end else if (us_tick) begin
      frame_d = (frame_q == FrameLast) ? '0 : frame_q + 1'b1;
    end

    // CUR moves only at the frame wrap, using the TARGET/STEP in force now;
    // reaching TARGET sets DONE, overriding a same-cycle software clear.
    if (boundary && busy) begin
      if (step_q == '0) begin
        cur_d = target_q;
      end else if (tgt_w > cur_w) begin
        cur_d = (sum_w >= tgt_w) ? target_q : sum_w[UsWidth-1:0];
      end else begin
        cur_d = (diff_w <= step_w) ? target_q : dec_w[UsWidth-1:0];
      end
      if (cur_d == target_q) begin
        done_d = 1'b1;
      end
    end

    // Built from next state so enable/disable take effect on the very next cycle
    pwm_d = enable_d && (32'(frame_d) < 32'(cur_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      target_q <= ResetUs;
      step_q   <= '0;
      cur_q    <= ResetUs;
      done_q   <= 1'b0;
      frame_q  <= '0;
      pwm_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      target_q <= target_d;
      step_q   <= step_d;
      cur_q    <= cur_d;
      done_q   <= done_d;
      frame_q  <= frame_d;
      pwm_q    <= pwm_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      AddrCtrl: begin
        readdata[CtrlEnableBit] = enable_q;
        readdata[CtrlIrqEnBit]  = irq_en_q;
      end
      AddrTarget: readdata[UsWidth-1:0] = target_q;
      AddrStep:   readdata[UsWidth-1:0] = step_q;
      AddrStatus: begin
        readdata[UsWidth-1:0]  = cur_q;
        readdata[StatusBusyBit] = busy;
        readdata[StatusDoneBit] = done_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_servo_pwm_sequencer.sv
// Directed bench for servo_pwm_sequencer with small timing parameters
// (2 clk/us, 100 us frame, 10..20 us range, 15 us reset position).
module tb_servo_pwm_sequencer;
  import servo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        pwm_out;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int len;

  servo_pwm_sequencer #(
    .CLK_PER_US(2),
    .PERIOD_US (100),
    .MIN_US    (10),
    .MAX_US    (20),
    .RESET_US  (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .pwm_out   (pwm_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wait_level(input string tag, input logic lvl);
    int n = 0;
    while (pwm_out !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check(tag, {31'b0, pwm_out}, {31'b0, lvl});
  endtask

  // Counts consecutive negedges with pwm_out == lvl; optionally drives one
  // write on the at-th sample so it lands on the following rising edge.
  task automatic run_len(input logic lvl, input bit do_wr, input logic [1:0] a,
                         input logic [31:0] d, input int at, output int n);
    n = 0;
    while (pwm_out === lvl && n < 1000) begin
      n++;
      if (do_wr && n == at) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
      end else begin
        chipselect = 1'b0;
        write_n    = 1'b1;
      end
      @(negedge clk);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_high(input string tag, input int exp);
    int n;
    wait_level({tag, "_wait"}, 1'b1);
    run_len(1'b1, 1'b0, AddrCtrl, 32'h0, 0, n);
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = AddrCtrl;
    writedata  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pwm", {31'b0, pwm_out}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check_reg("rst_ctrl", AddrCtrl, 32'h0);
    check_reg("rst_target", AddrTarget, 32'd15);
    check_reg("rst_step", AddrStep, 32'h0);
    check_reg("rst_status", AddrStatus, 32'h0000F);
    reset = 1'b0;
    @(negedge clk);

    // TARGET clamping (disabled, so CUR stays put)
    bus_write(AddrTarget, 32'h3E8);
    check_reg("clamp_hi", AddrTarget, 32'd20);
    check_reg("busy_set", AddrStatus, 32'h1000F);
    bus_write(AddrTarget, 32'h0);
    check_reg("clamp_lo", AddrTarget, 32'd10);
    bus_write(AddrTarget, 32'd12);
    check_reg("clamp_mid", AddrTarget, 32'd12);
    bus_write(AddrTarget, 32'd15);
    check_reg("status_idle", AddrStatus, 32'h0000F);

    // Basic waveform: 30 clk high, 170 clk low
    bus_write(AddrCtrl, 32'h1);
    run_len(1'b1, 1'b0, AddrCtrl, 32'h0, 0, len);
    check("pulse_first", 32'(len), 32'd30);
    run_len(1'b0, 1'b0, AddrCtrl, 32'h0, 0, len);
    check("low_first", 32'(len), 32'd170);
    run_len(1'b1, 1'b0, AddrCtrl, 32'h0, 0, len);
    check("pulse_second", 32'(len), 32'd30);
    check_reg("status_run", AddrStatus, 32'h0000F);

    // Mid-frame TARGET write at frame count 5 leaves this pulse alone
    wait_level("midwr_wait", 1'b1);
    run_len(1'b1, 1'b1, AddrTarget, 32'd19, 11, len);
    check("midwr_pulse", 32'(len), 32'd30);
    check_reg("midwr_target", AddrTarget, 32'd19);
    check_reg("midwr_status", AddrStatus, 32'h1000F);
    run_len(1'b0, 1'b0, AddrCtrl, 32'h0, 0, len);
    check("midwr_low", 32'(len), 32'd170);
    run_len(1'b1, 1'b0, AddrCtrl, 32'h0, 0, len);
    check("midwr_next", 32'(len), 32'd38);
    check_reg("midwr_done", AddrStatus, 32'h20013);
    check("irq_masked0", {31'b0, irq}, 32'h0);

    // STEP=0 jump back down to 15
    bus_write(AddrTarget, 32'd15);
    check_high("jump_down", 30);
    check_reg("jump_status", AddrStatus, 32'h2000F);
    bus_write(AddrStatus, 32'h20000);
    check_reg("done_clear", AddrStatus, 32'h0000F);

    // Ramp 15 -> 20 with STEP=2: 17, 19, 20
    bus_write(AddrStep, 32'd2);
    bus_write(AddrTarget, 32'd20);
    check_reg("ramp_start", AddrStatus, 32'h1000F);
    check_high("ramp_17", 34);
    check_reg("ramp_st17", AddrStatus, 32'h10011);
    check_high("ramp_19", 38);
    check_reg("ramp_st19", AddrStatus, 32'h10013);
    check_high("ramp_20", 40);
    check_reg("ramp_st20", AddrStatus, 32'h20014);
    check("irq_masked1", {31'b0, irq}, 32'h0);
    bus_write(AddrCtrl, 32'h3);
    check("irq_on", {31'b0, irq}, 32'h1);
    bus_write(AddrStatus, 32'h20000);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // Ramp down 20 -> 17 saturates: 18, 17
    bus_write(AddrTarget, 32'd17);
    check_high("down_18", 36);
    check_high("down_17", 34);
    check_reg("down_status", AddrStatus, 32'h20011);
    check("irq_down", {31'b0, irq}, 32'h1);

    // DONE set and software clear on the same boundary edge
    bus_write(AddrCtrl, 32'h0);
    bus_write(AddrStep, 32'd0);
    bus_write(AddrTarget, 32'd15);
    bus_write(AddrStatus, 32'h20000);
    check_reg("race_pre", AddrStatus, 32'h10011);
    bus_write(AddrCtrl, 32'h3);
    check("race_enable_pwm", {31'b0, pwm_out}, 32'h1);
    run_len(1'b1, 1'b0, AddrCtrl, 32'h0, 0, len);
    check("race_pulse", 32'(len), 32'd34);
    run_len(1'b0, 1'b1, AddrStatus, 32'h20000, 166, len);
    check("race_low", 32'(len), 32'd166);
    check_reg("race_done", AddrStatus, 32'h2000F);
    check("race_irq", {31'b0, irq}, 32'h1);

    // Disable mid-pulse, then re-enable for a fresh frame
    repeat (6) @(negedge clk);
    check("dis_pre", {31'b0, pwm_out}, 32'h1);
    bus_write(AddrCtrl, 32'h0);
    check("dis_pwm", {31'b0, pwm_out}, 32'h0);
    repeat (5) @(negedge clk);
    check("dis_hold", {31'b0, pwm_out}, 32'h0);
    check_reg("dis_status", AddrStatus, 32'h2000F);
    check_reg("dis_target", AddrTarget, 32'd15);
    check("dis_irq", {31'b0, irq}, 32'h0);
    bus_write(AddrCtrl, 32'h1);
    check("reen_pwm", {31'b0, pwm_out}, 32'h1);
    run_len(1'b1, 1'b0, AddrCtrl, 32'h0, 0, len);
    check("reen_pulse", 32'(len), 32'd30);
    run_len(1'b0, 1'b0, AddrCtrl, 32'h0, 0, len);
    check("reen_low", 32'(len), 32'd170);

    // Asynchronous reset mid-pulse
    repeat (4) @(negedge clk);
    check("arst_pre", {31'b0, pwm_out}, 32'h1);
    #2 reset = 1'b1;
    #1 check("arst_pwm", {31'b0, pwm_out}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reg("arst_ctrl", AddrCtrl, 32'h0);
    check_reg("arst_status", AddrStatus, 32'h0000F);
    repeat (3) @(negedge clk);
    check("arst_idle", {31'b0, pwm_out}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
